alu_seq_mac: RTL and testbench

Parametrised next-generation accumulator ALU for picoMips cores. It does single-cycle add/move into the accumulator and a multi-cycle signed fixed-point multiply (radix-2 Booth, one bit per clock). Width, fraction bits and overflow policy are configurable. It sits between the decoder/register file and the ACC consumers, and uses a Start/Busy/Done handshake so the controller can stall on multiplies.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/booth_mul_seq.sv | 60 ++++++
 rtl/alu_seq_mac.sv | 122 ++++++++++++
 tb/tb_alu_seq_mac.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the picoMips accumulator ALU.
// Helpers work on a wide fixed width; callers size-cast to the datapath width.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      WB   = 2'd2
   } state_t;

   localparam int MAXW = 64;
   localparam int LIMW = 2 * MAXW;

   // ovf is the LSB so a (width+1)'() cast yields {value[width-1:0], ovf}
   typedef struct packed {
      logic [MAXW-1:0] value;
      logic            ovf;
   } lim_t;

   function automatic lim_t sat_limit(input logic signed [LIMW-1:0] v,
                                      input int width,
                                      input logic sat);
      logic signed [LIMW-1:0] hi;
      logic signed [LIMW-1:0] lo;
      lim_t r;
      hi = $signed((LIMW'(1'b1) << (width - 32'sd1)) - LIMW'(1'b1));
      lo = ~hi;
      r.value = v[MAXW-1:0];
      r.ovf   = 1'b0;
      if (v > hi) begin
         r.ovf   = 1'b1;
         r.value = sat ? hi[MAXW-1:0] : v[MAXW-1:0];
      end else if (v < lo) begin
         r.ovf   = 1'b1;
         r.value = sat ? lo[MAXW-1:0] : v[MAXW-1:0];
      end else begin
         r.ovf   = 1'b0;
      end
      return r;
   endfunction

   function automatic logic [MAXW-1:0] operand_sel(input logic sel_imm,
                                                   input logic sel_sw,
                                                   input logic sel_reg,
                                                   input logic [MAXW-1:0] imm,
                                                   input logic [MAXW-1:0] sw,
                                                   input logic [MAXW-1:0] reg_data);
      return ({MAXW{sel_imm}} & imm) | ({MAXW{sel_sw}} & sw) | ({MAXW{sel_reg}} & reg_data);
   endfunction

endpackage

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, one multiplier bit per step.
// The upper partial-product half carries one guard bit so -2^(WIDTH-1) operands cannot overflow.
module booth_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               last_step,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNTW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] m_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH:0]   a_r;
   logic             q1_r;
   logic [CNTW-1:0]  cnt_r;
   logic [WIDTH:0]   a_sum_s;

   // Booth recoding of the current multiplier bit pair
   always_comb begin
      a_sum_s = a_r;
      case ({q_r[0], q1_r})
         2'b01:   a_sum_s = a_r + {m_r[WIDTH-1], m_r};
         2'b10:   a_sum_s = a_r - {m_r[WIDTH-1], m_r};
         default: a_sum_s = a_r;
      endcase
   end

   // Operand load and arithmetic right shift of {a, q, q-1}
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         m_r   <= {WIDTH{1'b0}};
         q_r   <= {WIDTH{1'b0}};
         a_r   <= {(WIDTH+1){1'b0}};
         q1_r  <= 1'b0;
         cnt_r <= {CNTW{1'b0}};
      end else if (load) begin
         m_r   <= multiplicand;
         q_r   <= multiplier;
         a_r   <= {(WIDTH+1){1'b0}};
         q1_r  <= 1'b0;
         cnt_r <= {CNTW{1'b0}};
      end else if (step) begin
         a_r   <= {a_sum_s[WIDTH], a_sum_s[WIDTH:1]};
         q_r   <= {a_sum_s[0], q_r[WIDTH-1:1]};
         q1_r  <= q_r[0];
         cnt_r <= cnt_r + CNTW'(1'b1);
      end
   end

   assign last_step = step && (cnt_r == CNTW'(WIDTH - 1));
   assign product   = {a_r[WIDTH-1:0], q_r};

endmodule

// File: rtl/alu_seq_mac.sv
// Accumulator ALU: single-cycle add/move and multi-cycle signed Q-format multiply
// into ACC, with Start/Busy/Done handshake and sticky overflow.
module alu_seq_mac
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int FRAC  = 3,
   parameter int SAT   = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] Imm,
   input  logic [WIDTH-1:0] RegData,
   input  logic [WIDTH-1:0] SW,
   input  logic             SelImm,
   input  logic             SelSW,
   input  logic             SelRegData,
   input  logic             UseACC,
   input  logic             UseMul,
   input  logic             Start,
   input  logic             ClrOvf,
   output logic             Busy,
   output logic             Done,
   output logic             Ovf,
   output logic [WIDTH-1:0] ACC
);

   state_t                   state_r;
   logic                     busy_r;
   logic                     done_r;
   logic                     ovf_r;
   logic [WIDTH-1:0]         acc_r;

   logic [WIDTH-1:0]         data_s;
   logic [WIDTH:0]           acc_ext_s;
   logic signed [WIDTH:0]    sum_s;
   logic [WIDTH:0]           add_lim_s;
   logic [WIDTH:0]           mul_lim_s;
   logic [2*WIDTH-1:0]       product_s;
   logic signed [2*WIDTH-1:0] shifted_s;
   logic                     mul_load_s;
   logic                     mul_step_s;
   logic                     mul_last_s;

   assign data_s    = WIDTH'(operand_sel(SelImm, SelSW, SelRegData,
                                         MAXW'(Imm), MAXW'(SW), MAXW'(RegData)));
   assign acc_ext_s = UseACC ? {acc_r[WIDTH-1], acc_r} : {(WIDTH+1){1'b0}};
   assign sum_s     = $signed(acc_ext_s + {data_s[WIDTH-1], data_s});
   assign add_lim_s = (WIDTH+1)'(sat_limit(LIMW'(sum_s), WIDTH, SAT != 32'sd0));

   // Floor rounding: arithmetic shift drops the fraction bits
   assign shifted_s = $signed(product_s) >>> FRAC;
   assign mul_lim_s = (WIDTH+1)'(sat_limit(LIMW'(shifted_s), WIDTH, SAT != 32'sd0));

   assign mul_load_s = (state_r == IDLE) && Start && UseMul;
   assign mul_step_s = (state_r == MUL);

   booth_mul_seq #(.WIDTH(WIDTH)) u_booth (
      .Clock        (Clock),
      .Reset        (Reset),
      .load         (mul_load_s),
      .step         (mul_step_s),
      .multiplicand (sum_s[WIDTH-1:0]),
      .multiplier   (Imm),
      .last_step    (mul_last_s),
      .product      (product_s)
   );

   // Control FSM with ACC, handshake and sticky overflow registers
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         ovf_r   <= 1'b0;
         acc_r   <= {WIDTH{1'b0}};
      end else begin
         done_r <= 1'b0;
         if (ClrOvf) begin
            ovf_r <= 1'b0;
         end
         case (state_r)
            IDLE: begin
               if (Start && UseMul) begin
                  state_r <= MUL;
                  busy_r  <= 1'b1;
               end else if (Start) begin
                  acc_r  <= add_lim_s[WIDTH:1];
                  done_r <= 1'b1;
                  if (add_lim_s[0]) begin
                     ovf_r <= 1'b1;
                  end
               end
            end
            MUL: begin
               if (mul_last_s) begin
                  state_r <= WB;
               end
            end
            WB: begin
               acc_r   <= mul_lim_s[WIDTH:1];
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= IDLE;
               if (mul_lim_s[0]) begin
                  ovf_r <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign Busy = busy_r;
   assign Done = done_r;
   assign Ovf  = ovf_r;
   assign ACC  = acc_r;

endmodule

// File: tb/tb_alu_seq_mac.sv
// Randomised self-checking bench for alu_seq_mac: a saturating and a wrapping
// instance share stimulus and are compared against an arithmetic reference model.
module tb_alu_seq_mac;

   logic       Clock = 1'b0;
   logic       Reset;
   logic [7:0] Imm, RegData, SW;
   logic       SelImm, SelSW, SelRegData, UseACC, UseMul, Start, ClrOvf;
   logic       busy_s, done_s, ovf_s;
   logic [7:0] acc_s;
   logic       busy_w, done_w, ovf_w;
   logic [7:0] acc_w;

   int n_tests = 0;
   int n_fail  = 0;
   int acc_m1 = 0, acc_m0 = 0;
   bit ovf_m1 = 1'b0, ovf_m0 = 1'b0;

   always #5 Clock = ~Clock;

   alu_seq_mac #(.WIDTH(8), .FRAC(3), .SAT(1)) u_dut_sat (
      .Clock(Clock), .Reset(Reset), .Imm(Imm), .RegData(RegData), .SW(SW),
      .SelImm(SelImm), .SelSW(SelSW), .SelRegData(SelRegData), .UseACC(UseACC),
      .UseMul(UseMul), .Start(Start), .ClrOvf(ClrOvf),
      .Busy(busy_s), .Done(done_s), .Ovf(ovf_s), .ACC(acc_s)
   );

   alu_seq_mac #(.WIDTH(8), .FRAC(3), .SAT(0)) u_dut_wrap (
      .Clock(Clock), .Reset(Reset), .Imm(Imm), .RegData(RegData), .SW(SW),
      .SelImm(SelImm), .SelSW(SelSW), .SelRegData(SelRegData), .UseACC(UseACC),
      .UseMul(UseMul), .Start(Start), .ClrOvf(ClrOvf),
      .Busy(busy_w), .Done(done_w), .Ovf(ovf_w), .ACC(acc_w)
   );

   task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference: result of the operation currently on the inputs, from the given ACC
   function automatic void model(input int acc, input int sat, output int res, output bit ovf);
      logic [7:0] d;
      logic [7:0] t;
      int sum, r;
      d = 8'h00;
      if (SelImm)     d = d | Imm;
      if (SelSW)      d = d | SW;
      if (SelRegData) d = d | RegData;
      sum = (UseACC ? acc : 0) + int'($signed(d));
      if (UseMul) begin
         t = sum[7:0];
         r = (int'($signed(t)) * int'($signed(Imm))) >>> 3;
      end else begin
         r = sum;
      end
      ovf = (r > 127) || (r < -128);
      if (!ovf) res = r;
      else if (sat != 0) res = (r > 127) ? 127 : -128;
      else begin
         t = r[7:0];
         res = int'($signed(t));
      end
   endfunction

   task automatic set_ops(input logic [7:0] imm, input logic [7:0] sw, input logic [7:0] rd,
                          input logic si, input logic ss, input logic sr,
                          input logic ua, input logic um);
      Imm = imm; SW = sw; RegData = rd;
      SelImm = si; SelSW = ss; SelRegData = sr; UseACC = ua; UseMul = um;
   endtask

   task automatic scramble();
      Imm = 8'($urandom); SW = 8'($urandom); RegData = 8'($urandom);
      SelImm = 1'($urandom); SelSW = 1'($urandom); SelRegData = 1'($urandom);
      UseACC = 1'($urandom); UseMul = 1'($urandom); Start = 1'($urandom);
   endtask

   task automatic run_op();
      int exp1, exp0, bc, cyc;
      bit o1, o0;
      bit is_mul;
      is_mul = UseMul;
      model(acc_m1, 1, exp1, o1);
      model(acc_m0, 0, exp0, o0);
      Start = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0;
      if (!is_mul) begin
         check("add_busy", busy_s, 0);
      end else begin
         bc = 0;
         cyc = 0;
         while (done_s !== 1'b1 && cyc < 30) begin
            if (busy_s === 1'b1) bc++;
            check("hold_acc_sat", $signed(acc_s), acc_m1);
            check("hold_acc_wrap", $signed(acc_w), acc_m0);
            scramble();
            @(posedge Clock); #1;
            cyc++;
         end
         Start = 1'b0;
         check("busy_cycles", bc, 9);
         check("wb_busy", busy_s, 0);
      end
      acc_m1 = exp1; acc_m0 = exp0;
      ovf_m1 = ovf_m1 | o1; ovf_m0 = ovf_m0 | o0;
      check("done_sat", done_s, 1);
      check("done_wrap", done_w, 1);
      check("acc_sat", $signed(acc_s), acc_m1);
      check("acc_wrap", $signed(acc_w), acc_m0);
      check("ovf_sat", ovf_s, ovf_m1);
      check("ovf_wrap", ovf_w, ovf_m0);
   endtask

   task automatic idle_check();
      Start = 1'b0;
      @(posedge Clock); #1;
      check("done_pulse", done_s, 0);
      check("idle_busy", busy_s, 0);
   endtask

   task automatic clr_ovf();
      Start = 1'b0;
      ClrOvf = 1'b1;
      @(posedge Clock); #1;
      ClrOvf = 1'b0;
      ovf_m1 = 1'b0; ovf_m0 = 1'b0;
      check("clr_ovf_sat", ovf_s, 0);
      check("clr_ovf_wrap", ovf_w, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1; Start = 1'b0; ClrOvf = 1'b0;
      set_ops(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge Clock);
      #1;
      check("rst_acc", acc_s, 0);
      check("rst_busy", busy_s, 0);
      check("rst_done", done_s, 0);
      check("rst_ovf", ovf_s, 0);
      Reset = 1'b0;

      // Move, then multiply by 2.0
      set_ops(8'h00, 8'd20, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); run_op();
      check("dir_move20", $signed(acc_s), 20);
      idle_check();
      set_ops(8'd16, 8'd4, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1); run_op();
      check("dir_mul2", $signed(acc_s), 48);

      // Product overflow: saturate vs wrap, then clear
      set_ops(8'h00, 8'd100, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); run_op();
      set_ops(8'd24, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1); run_op();
      check("dir_mul3_sat", $signed(acc_s), 127);
      check("dir_mul3_wrap", $signed(acc_w), 44);
      clr_ovf();

      // Signed operands and floor rounding
      set_ops(8'h00, 8'hF6, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); run_op();
      set_ops(8'hF4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); run_op();
      check("dir_negneg", $signed(acc_s), 15);
      set_ops(8'h00, 8'hFD, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); run_op();
      set_ops(8'd4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); run_op();
      check("dir_floor", $signed(acc_s), -2);

      // Move-through by 1.0, issued back-to-back on the WB-exit cycle
      set_ops(8'd8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); run_op();
      check("dir_unity", $signed(acc_s), -2);

      // Add overflow
      set_ops(8'h00, 8'd120, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); run_op();
      set_ops(8'h00, 8'd20, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); run_op();
      check("dir_addsat", $signed(acc_s), 127);
      check("dir_addwrap", $signed(acc_w), -116);

      for (int i = 0; i < 40; i++) begin
         Imm = 8'($urandom); SW = 8'($urandom); RegData = 8'($urandom);
         SelImm = 1'b0; SelSW = 1'b0; SelRegData = 1'b0;
         case ($urandom_range(0, 4))
            0: ;
            1: SelImm = 1'b1;
            2: SelSW = 1'b1;
            3: SelRegData = 1'b1;
            default: begin SelImm = 1'b1; SelSW = 1'b1; SelRegData = 1'b1; end
         endcase
         UseACC = 1'($urandom);
         UseMul = 1'($urandom);
         run_op();
         if ($urandom_range(0, 3) == 0) clr_ovf();
         if ($urandom_range(0, 2) == 0) idle_check();
      end

      // Reset in the middle of a multiply, with Ovf and ACC non-zero
      set_ops(8'h00, 8'd120, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); run_op();
      set_ops(8'h00, 8'd20, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); run_op();
      set_ops(8'd16, 8'd5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      Start = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0;
      repeat (3) @(posedge Clock);
      #2;
      Reset = 1'b1;
      #1;
      check("midrst_acc", acc_s, 0);
      check("midrst_busy", busy_s, 0);
      check("midrst_done", done_s, 0);
      check("midrst_ovf", ovf_s, 0);
      check("midrst_ovf_wrap", ovf_w, 0);
      @(posedge Clock); #1;
      Reset = 1'b0;
      acc_m1 = 0; acc_m0 = 0; ovf_m1 = 1'b0; ovf_m0 = 1'b0;
      set_ops(8'd16, 8'd5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); run_op();
      check("postrst_mul", $signed(acc_s), 10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
